// File: rtl/syn_unit.sv
// Synapse lookup stage: accepts synapse addresses, reads {weight, target} from
// local memory and queues non-zero-weight charge events for the neuron stage.
module syn_unit #(
   parameter int ADDR_W     = 10,
   parameter int WEIGHT_W   = 8,
   parameter int TARGET_W   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         syn_vld,
   input  logic [ADDR_W-1:0]            syn_addr,
   output logic                         syn_rdy,
   input  logic                         cfg_we,
   input  logic [ADDR_W-1:0]            cfg_addr,
   input  logic [WEIGHT_W+TARGET_W-1:0] cfg_data,
   output logic                         chg_vld,
   input  logic                         chg_rdy,
   output logic [WEIGHT_W-1:0]          chg_weight,
   output logic [TARGET_W-1:0]          chg_target,
   output logic                         step_done
);

   localparam int DATA_W = WEIGHT_W + TARGET_W;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int OCC_W  = PTR_W + 1;
   localparam logic [OCC_W:0] DEPTH_F = (OCC_W + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data;
   logic              pend;

   logic [DATA_W-1:0] fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  occ;

   logic              accept;
   logic              push;
   logic              pop;
   logic [OCC_W:0]    fill;
   logic [DATA_W-1:0] head;

   // Reserve a FIFO slot for the read in flight so the push can never overflow.
   always_comb begin
      fill    = {1'b0, occ} + {{OCC_W{1'b0}}, pend};
      syn_rdy = enable && reset && (fill < DEPTH_F);
      accept  = syn_vld && syn_rdy;
   end

   always_comb begin
      push       = pend && (rd_data[DATA_W-1 -: WEIGHT_W] != '0);
      chg_vld    = reset && (occ != '0);
      pop        = chg_vld && chg_rdy;
      head       = fifo[rd_ptr];
      chg_weight = head[DATA_W-1 -: WEIGHT_W];
      chg_target = head[TARGET_W-1:0];
   end

   // Read-before-write on address collision falls out of non-blocking ordering.
   always_ff @(posedge clk) begin
      if (cfg_we) begin
         mem[cfg_addr] <= cfg_data;
      end
      if (accept) begin
         rd_data <= mem[syn_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_ptr] <= rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend      <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         step_done <= 1'b1;
      end else begin
         pend      <= accept;
         step_done <= !pend && (occ == '0) && !accept;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_unit.sv
// Self-checking bench for syn_unit: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based behavioural model.
module tb_syn_unit;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        syn_vld;
   logic [AW-1:0] syn_addr;
   logic        syn_rdy;
   logic        cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [15:0] cfg_data;
   logic        chg_vld;
   logic        chg_rdy;
   logic [7:0]  chg_weight;
   logic [7:0]  chg_target;
   logic        step_done;

   syn_unit #(
      .ADDR_W     (AW),
      .WEIGHT_W   (8),
      .TARGET_W   (8),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .syn_vld    (syn_vld),
      .syn_addr   (syn_addr),
      .syn_rdy    (syn_rdy),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .chg_vld    (chg_vld),
      .chg_rdy    (chg_rdy),
      .chg_weight (chg_weight),
      .chg_target (chg_target),
      .step_done  (step_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model: memory image, event queue, one read in flight.
   logic [15:0] mem_m [2**AW];
   logic [15:0] q [$];
   bit          pend_m = 1'b0;
   logic [15:0] pend_e = '0;
   bit          done_m = 1'b1;
   bit          chk_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare outputs mid-cycle, advance the model across the coming edge.
   task automatic step();
      bit exp_rdy, exp_vld, acc, pop, ovf;
      int sz;
      @(negedge clk);
      sz      = q.size();
      exp_rdy = enable && reset && ((sz + int'(pend_m)) < DEPTH);
      exp_vld = reset && (sz != 0);
      if (chk_on) begin
         check("syn_rdy", 32'(syn_rdy), 32'(exp_rdy));
         check("chg_vld", 32'(chg_vld), 32'(exp_vld));
         if (exp_vld) begin
            check("chg_weight", 32'(chg_weight), 32'(q[0][15:8]));
            check("chg_target", 32'(chg_target), 32'(q[0][7:0]));
         end
         check("step_done", 32'(step_done), 32'(done_m));
         ovf = dut.push && (int'(dut.occ) == DEPTH);
         check("no_overflow", 32'(ovf), 32'd0);
      end
      if (!reset) begin
         q.delete();
         pend_m = 1'b0;
         done_m = 1'b1;
      end else begin
         acc    = syn_vld && exp_rdy;
         pop    = exp_vld && chg_rdy;
         done_m = !pend_m && (sz == 0) && !acc;
         if (pop) void'(q.pop_front());
         if (pend_m && (pend_e[15:8] != 8'd0)) q.push_back(pend_e);
         pend_m = acc;
         if (acc) pend_e = mem_m[syn_addr];
      end
      if (cfg_we) mem_m[cfg_addr] = cfg_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      syn_vld = 1'b0;
      cfg_we  = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cfg_write(input int a, input logic [15:0] d);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_data = d;
      step();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int n;
      logic [7:0] w;
      logic [15:0] ref20;
      reset = 1'b0; enable = 1'b0; syn_vld = 1'b0; syn_addr = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; chg_rdy = 1'b0;
      #1;
      step();
      chk_on = 1'b1;
      step();
      check("reset_rdy", 32'(syn_rdy), 32'd0);
      check("reset_done", 32'(step_done), 32'd1);
      reset  = 1'b1;
      enable = 1'b1;

      for (int a = 0; a < 2**AW; a++) begin
         w = 8'($urandom_range(0, 255));
         if (a < 32 && w == 8'd0) w = 8'd1;
         if (a >= 32 && $urandom_range(0, 7) == 0) w = 8'd0;
         if (a == 5) cfg_write(a, {8'd3, 8'd7});
         else        cfg_write(a, {w, 8'($urandom_range(0, 255))});
      end
      idle(2);

      // Single lookup latency and one-cycle event.
      chg_rdy = 1'b1;
      syn_vld = 1'b1; syn_addr = AW'(5);
      step();
      syn_vld = 1'b0;
      step();
      check("lat_vld", 32'(chg_vld), 32'd1);
      check("lat_weight", 32'(chg_weight), 32'd3);
      check("lat_target", 32'(chg_target), 32'd7);
      step();
      check("lat_once", 32'(chg_vld), 32'd0);
      idle(2);

      // Back-to-back stream with free-flowing output.
      for (int i = 0; i < 16; i++) begin
         syn_vld = 1'b1; syn_addr = AW'(i);
         check("b2b_rdy", 32'(syn_rdy), 32'd1);
         step();
      end
      idle(4);

      // Backpressure: fill to depth, then release.
      chg_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         syn_vld = 1'b1; syn_addr = AW'(20 + i);
         step();
      end
      syn_vld = 1'b0;
      step();
      check("bp_stall", 32'(syn_rdy), 32'd0);
      chg_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (chg_vld) n++;
         step();
      end
      check("bp_count", 32'(n), 32'd4);

      // Zero-weight entry produces no event.
      cfg_write(9, {8'd0, 8'd55});
      idle(2);
      syn_vld = 1'b1; syn_addr = AW'(9);
      step();
      syn_vld = 1'b0;
      step();
      check("zero_vld1", 32'(chg_vld), 32'd0);
      check("zero_busy", 32'(step_done), 32'd0);
      step();
      check("zero_vld2", 32'(chg_vld), 32'd0);
      check("zero_done", 32'(step_done), 32'd1);

      // Read/write collision returns pre-write data.
      cfg_write(3, {8'd4, 8'd1});
      idle(1);
      cfg_we = 1'b1; cfg_addr = AW'(3); cfg_data = {8'hFF, 8'd2};
      syn_vld = 1'b1; syn_addr = AW'(3);
      step();
      cfg_we = 1'b0; syn_vld = 1'b0;
      step();
      check("coll_old_w", 32'(chg_weight), 32'd4);
      check("coll_old_t", 32'(chg_target), 32'd1);
      step();
      syn_vld = 1'b1; syn_addr = AW'(3);
      step();
      syn_vld = 1'b0;
      step();
      check("coll_new_w", 32'(chg_weight), 32'hFF);
      check("coll_new_t", 32'(chg_target), 32'd2);
      idle(3);

      // Mid-operation reset with three queued entries and a read in flight.
      chg_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         syn_vld = 1'b1; syn_addr = AW'(20 + i);
         step();
      end
      syn_vld = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      check("rst_vld", 32'(chg_vld), 32'd0);
      check("rst_done", 32'(step_done), 32'd1);
      chg_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rst_stale", 32'(chg_vld), 32'd0);
         step();
      end
      ref20 = mem_m[20];
      syn_vld = 1'b1; syn_addr = AW'(20);
      step();
      syn_vld = 1'b0;
      step();
      check("rst_mem_w", 32'(chg_weight), 32'(ref20[15:8]));
      check("rst_mem_t", 32'(chg_target), 32'(ref20[7:0]));
      idle(3);

      // Random traffic, including disabled cycles, collisions and resets.
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 149) != 0);
         enable   = ($urandom_range(0, 9) < 8);
         syn_vld  = ($urandom_range(0, 9) < 7);
         syn_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         chg_rdy  = ($urandom_range(0, 9) < 6);
         cfg_we   = ($urandom_range(0, 9) == 0);
         cfg_addr = ($urandom_range(0, 1) == 0) ? syn_addr : AW'($urandom);
         cfg_data = 16'($urandom);
         step();
      end
      reset = 1'b1; enable = 1'b1; chg_rdy = 1'b1;
      idle(10);
      check("final_done", 32'(step_done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/syn_unit.md
SYN_UNIT -- requirements
Module: syn_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, synapse-memory address width.
REQ-002 SHALL have parameter WEIGHT_W, default 8, signed synapse weight width.
REQ-003 SHALL have parameter TARGET_W, default 8, target neuron id width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=4).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset (asserted when 0).
REQ-007 SHALL have port enable, input, 1, permits acceptance of new synapse addresses.
REQ-008 SHALL have port syn_vld, input, 1, synapse address valid from fire dispatch.
REQ-009 SHALL have port syn_addr, input, ADDR_W, synapse memory index to read.
REQ-010 SHALL have port syn_rdy, output, 1, unit can accept syn_addr this cycle.
REQ-011 SHALL have ports cfg_we (input, 1), cfg_addr (input, ADDR_W), cfg_data (input, WEIGHT_W+TARGET_W), synapse memory write port; cfg_data = {weight, target}.
REQ-012 SHALL have ports chg_vld (output, 1), chg_rdy (input, 1), chg_weight (output, WEIGHT_W), chg_target (output, TARGET_W), charge event to neuron stage.
REQ-013 SHALL have port step_done, output, 1, registered idle indication.

Function
REQ-014 SHALL hold 2^ADDR_W entries of synapse memory, synchronous read, one read port, one write port; contents are not cleared by reset.
REQ-015 SHALL accept an address on a cycle where syn_vld && syn_rdy at the rising edge; syn_addr captured into the read at that edge.
REQ-016 SHALL drive syn_rdy = enable && reset && (occ + pend) < FIFO_DEPTH, where occ = registered FIFO occupancy and pend = registered one-bit read-in-flight flag; syn_rdy depends on no other input.
REQ-017 SHALL set pend for exactly the cycle following each accept; read data is valid in that cycle.
REQ-018 SHALL push {weight, target} into the output FIFO at the edge ending the pend cycle, unless weight == 0, in which case the entry is dropped and no event is produced.
REQ-019 SHALL give latency: accept at edge t -> chg_vld high in the cycle after edge t+1 when FIFO was empty (two edges).
REQ-020 SHALL sustain one accept per cycle indefinitely while chg_rdy is held 1.
REQ-021 SHALL drive chg_vld = (occ != 0) with chg_weight/chg_target from FIFO head; pop on chg_vld && chg_rdy.
REQ-022 SHALL hold chg_vld, chg_weight, chg_target stable while chg_vld && !chg_rdy.
REQ-023 SHALL, on simultaneous push and pop, leave occ unchanged and preserve order; simultaneous push-and-pop on a one-entry FIFO is legal.
REQ-024 SHALL never overflow: push with occ == FIFO_DEPTH is impossible by REQ-016; bench SHALL assert this.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-026 SHALL, when cfg_we and an accepted read hit the same address on one edge, return the old (pre-write) data for the read; the write takes effect afterward.
REQ-027 SHALL accept cfg writes regardless of enable.
REQ-028 SHALL, with enable low, stop accepting but complete any pending read and keep draining the FIFO.
REQ-029 SHALL register step_done = !pend && occ == 0 && !(syn_vld && syn_rdy), updated every edge.

Reset
REQ-030 SHALL, while reset == 0 at an edge, clear occ, pointers and pend; syn_rdy = 0 and chg_vld = 0 during reset cycles; step_done = 1 the cycle after.
REQ-031 SHALL discard in-flight reads and FIFO contents on reset mid-operation; no event from before reset appears afterward.
REQ-032 SHALL leave synapse memory contents intact across reset.

Verification
REQ-033 SHALL test: write addr 5 = {w=+3, t=7}; accept addr 5 at edge t, chg_rdy=1 -> chg_vld=1, weight 3, target 7 after edge t+1, one cycle only.
REQ-034 SHALL test: addrs 0..15 back-to-back, chg_rdy=1, all weights non-zero -> syn_rdy never drops, 16 events in order, one per cycle.
REQ-035 SHALL test: chg_rdy=0, stream addrs -> syn_rdy falls once occ+pend = 4; exactly 4 events held, released in order when chg_rdy=1.
REQ-036 SHALL test: addr 9 has weight 0 -> accepted, no chg_vld; step_done returns 1 two edges after accept.
REQ-037 SHALL test: cfg write {w=-1,t=2} to addr 3 on same edge as accept of addr 3 (old {w=4,t=1}) -> event w=4,t=1; next read gives w=-1,t=2.
REQ-038 SHALL test: reset=0 for one cycle with FIFO holding 3 entries and pend=1 -> chg_vld=0, occ=0, no stale events after reset=1; memory reads unchanged.
